// File: rtl/dmem_ctrl.sv
// Word-organised data memory behind a single-outstanding load/store port with RISC-V funct3 decode.
// Optional post-reset zero sweep of the array is enabled by defining DMEM_CLEAR_ON_RESET_EN.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam state_e StReset = StClear;
`else
  localparam state_e StReset = StIdle;
`endif

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     hold_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            err_q, we_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic            accept;
  logic [AW-1:0]   req_idx;
  logic            f3_legal, misaligned, out_of_range, req_err;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic [31:0]     src_word;
  logic [2:0]      src_f3;
  logic [1:0]      src_off;
  logic            src_err, src_we;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  assign accept  = i_req_valid & o_req_ready;
  assign req_idx = i_req_addr[AW+1:2];

  always_comb begin
    f3_legal     = i_req_we ? (i_req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = 1'b0;
    if (i_req_funct3[1:0] == 2'b01) misaligned = i_req_addr[0];
    if (i_req_funct3[1:0] == 2'b10) misaligned = |i_req_addr[1:0];
    out_of_range = |i_req_addr[31:AW+2];
    req_err      = ~f3_legal | misaligned | out_of_range;
  end

  // Store data is replicated across lanes so the byte-enables alone pick the target lanes.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = i_req_wdata;
    if (i_req_funct3[1:0] == 2'b00) begin
      st_be    = 4'b0001 << i_req_addr[1:0];
      st_wdata = {4{i_req_wdata[7:0]}};
    end else if (i_req_funct3[1:0] == 2'b01) begin
      st_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{i_req_wdata[15:0]}};
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [AW-1:0] clr_idx_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_idx_q <= '0;
    end else if (state_q == StClear) begin
      clr_idx_q <= clr_idx_q + 1'b1;
    end
  end
`endif

  always_comb begin
    mem_we    = accept & i_req_we & ~req_err;
    mem_idx   = req_idx;
    mem_be    = st_be;
    mem_wdata = st_wdata;
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx_q;
      mem_be    = 4'hF;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (clr_idx_q == AW'(DEPTH_WORDS - 1)) state_d = StIdle;
`else
        state_d = StIdle;
`endif
      end
      StIdle, StResp: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 2'(LATENCY - 2);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // With single-cycle latency the response is formed straight from the accept-edge request.
  always_comb begin
    src_word = (LATENCY == 1) ? mem[req_idx]  : hold_q;
    src_f3   = (LATENCY == 1) ? i_req_funct3  : f3_q;
    src_off  = (LATENCY == 1) ? i_req_addr[1:0] : off_q;
    src_err  = (LATENCY == 1) ? req_err       : err_q;
    src_we   = (LATENCY == 1) ? i_req_we      : we_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      hold_q      <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hold_q <= mem[req_idx];
        f3_q   <= i_req_funct3;
        off_q  <= i_req_addr[1:0];
        err_q  <= req_err;
        we_q   <= i_req_we;
      end
      if (state_d == StResp) begin
        rsp_rdata_q <= (src_err | src_we) ? 32'b0 : load_ext(src_word, src_f3, src_off);
        rsp_err_q   <= src_err;
      end
    end
  end

  assign o_req_ready = (state_q == StIdle) || (state_q == StResp);
  assign o_rsp_valid = (state_q == StResp);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = (state_q == StClear);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: lanes, extension, faults, latency,
// throughput and reset during an outstanding request.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 16;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic RDY_RST  = 1'b0;
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic RDY_RST  = 1'b1;
  localparam logic BUSY_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rst4_n;
  logic [2:0]  req_valid;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic [2:0]  req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_busy(busy[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_busy(busy[1])
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_funct3(req_f3),
    .o_rsp_valid(rsp_valid[2]), .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]),
    .o_busy(busy[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_f3    = f3;
  endtask

  // One transaction on DUT d, waiting a bounded number of cycles for its response.
  task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    set_req(we, addr, wdata, f3);
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rsp_seen", {31'b0, rsp_valid[d]}, 32'd1);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    rst_n     = 1'b0;
    rst4_n    = 1'b0;
    req_valid = '0;
    set_req(1'b0, 32'h0, 32'h0, 3'b000);
    #12;
    check_eq("rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
    check_eq("rst_err",   {31'b0, rsp_err[0]},   32'd0);
    check_eq("rst_rdata", rsp_rdata[0],          32'h0);
    check_eq("rst_ready", {31'b0, req_ready[0]}, {31'b0, RDY_RST});
    check_eq("rst_busy",  {31'b0, busy[0]},      {31'b0, BUSY_RST});
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

`ifdef DMEM_CLEAR_ON_RESET_EN
    n = 0;
    while (busy[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("clear_cycles", n, DEPTH);
    check_eq("clear_ready", {31'b0, req_ready[0]}, 32'd1);
    xfer(0, 1'b0, 32'h3C, 32'h0, 3'b010, rd, er);
    check_eq("clear_lw_data", rd, 32'h0);
    check_eq("clear_lw_err", {31'b0, er}, 32'd0);
`endif

    // Lane steering and extension
    xfer(0, 1'b1, 32'h10, 32'h8899AABB, 3'b010, rd, er);
    check_eq("sw_rdata", rd, 32'h0);
    check_eq("sw_err", {31'b0, er}, 32'd0);
    xfer(0, 1'b1, 32'h11, 32'h0000007F, 3'b000, rd, er);
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    check_eq("lw_10", rd, 32'h88997FBB);
    xfer(0, 1'b0, 32'h13, 32'h0, 3'b000, rd, er);
    check_eq("lb_13", rd, 32'hFFFFFF88);
    xfer(0, 1'b0, 32'h13, 32'h0, 3'b100, rd, er);
    check_eq("lbu_13", rd, 32'h00000088);
    xfer(0, 1'b0, 32'h12, 32'h0, 3'b001, rd, er);
    check_eq("lh_12", rd, 32'hFFFF8899);
    xfer(0, 1'b0, 32'h10, 32'h0, 3'b101, rd, er);
    check_eq("lhu_10", rd, 32'h00007FBB);
    check_eq("lhu_err", {31'b0, er}, 32'd0);

    // Faults
    xfer(0, 1'b1, 32'h04, 32'h11223344, 3'b010, rd, er);
    xfer(0, 1'b0, 32'h02, 32'h0, 3'b010, rd, er);
    check_eq("lw_mis_err", {31'b0, er}, 32'd1);
    check_eq("lw_mis_data", rd, 32'h0);
    xfer(0, 1'b1, 32'h05, 32'h0000BEEF, 3'b001, rd, er);
    check_eq("sh_mis_err", {31'b0, er}, 32'd1);
    xfer(0, 1'b0, 32'h04, 32'h0, 3'b010, rd, er);
    check_eq("sh_mis_nowrite", rd, 32'h11223344);
    check_eq("lw_04_err", {31'b0, er}, 32'd0);
    xfer(0, 1'b0, 32'h08, 32'h0, 3'b011, rd, er);
    check_eq("f3_011_err", {31'b0, er}, 32'd1);
    xfer(0, 1'b0, 4 * DEPTH, 32'h0, 3'b010, rd, er);
    check_eq("oor_err", {31'b0, er}, 32'd1);
    check_eq("oor_data", rd, 32'h0);

    // Throughput at single-cycle latency
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b1, 32'h20 + 4 * i, 32'hA0000000 | i, 3'b010, rd, er);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_req(1'b0, 32'h20 + 4 * i, 32'h0, 3'b010);
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      check_eq("b2b_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check_eq("b2b_data", rsp_rdata[0], 32'hA0000000 | i);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("b2b_end_valid", {31'b0, rsp_valid[0]}, 32'd0);

    // Store then load on adjacent edges
    @(negedge clk);
    set_req(1'b1, 32'h24, 32'hCAFEF00D, 3'b010);
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 32'h24, 32'h0, 3'b010);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check_eq("raw_valid", {31'b0, rsp_valid[0]}, 32'd1);
    check_eq("raw_data", rsp_rdata[0], 32'hCAFEF00D);

    // Latency 3 timing
    xfer(1, 1'b1, 32'h08, 32'hA5A55A5A, 3'b010, rd, er);
    @(negedge clk);
    set_req(1'b0, 32'h08, 32'h0, 3'b010);
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    check_eq("lat_e0_ready", {31'b0, req_ready[1]}, 32'd0);
    check_eq("lat_e0_valid", {31'b0, rsp_valid[1]}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_e1_ready", {31'b0, req_ready[1]}, 32'd0);
    check_eq("lat_e1_valid", {31'b0, rsp_valid[1]}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_e2_valid", {31'b0, rsp_valid[1]}, 32'd1);
    check_eq("lat_e2_data", rsp_rdata[1], 32'hA5A55A5A);
    @(posedge clk);
    #1;
    check_eq("lat_e3_valid", {31'b0, rsp_valid[1]}, 32'd0);
    check_eq("lat_e3_hold", rsp_rdata[1], 32'hA5A55A5A);

    // Reset during WAIT at latency 4
    xfer(2, 1'b1, 32'h00, 32'h12345678, 3'b010, rd, er);
    xfer(2, 1'b0, 32'h00, 32'h0, 3'b010, rd, er);
    check_eq("l4_data", rd, 32'h12345678);
    @(negedge clk);
    set_req(1'b0, 32'h00, 32'h0, 3'b010);
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst4_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'b0, rsp_valid[2]}, 32'd0);
    check_eq("mid_rst_err",   {31'b0, rsp_err[2]},   32'd0);
    check_eq("mid_rst_rdata", rsp_rdata[2],          32'h0);
    @(negedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[2]) n++;
    end
    check_eq("mid_rst_no_rsp", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the RISC-V core's load/store path: word-organised SRAM of configurable depth behind a single-outstanding valid/ready request port with configurable read latency. Decodes RISC-V load/store `funct3` directly, performs byte-lane steering and load sign/zero extension internally, and flags misaligned, illegal or out-of-range accesses. Optionally sweeps the array to zero after reset.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `LATENCY`, 1: cycles from request acceptance to response, 1..4.

Ports (clock and reset first):
- `i_clk`  in  1: single clock; all logic on rising edge.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_req_valid`  in  1: request present.
- `o_req_ready`  out  1: controller can accept; handshake when both high at a rising edge.
- `i_req_we`  in  1: 1 = store, 0 = load.
- `i_req_addr`  in  32: byte address.
- `i_req_wdata`  in  32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- `i_req_funct3`  in  3: RISC-V size/sign code.
- `o_rsp_valid`  out  1: one-cycle response pulse.
- `o_rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `o_rsp_err`  out  1: access fault, valid with `o_rsp_valid`.
- `o_busy`  out  1: clear sweep in progress.

## Operation
- States: CLEAR, IDLE, WAIT, RESP. `o_req_ready` = 1 in IDLE and RESP only.
- On accept: latch `funct3`, `addr[1:0]`, and error. Loads read the word at `addr[log2(DEPTH_WORDS)+1:2]` into a holding register.
- Stores write at the accept edge with byte-enables:
  - SB: lane `addr[1:0]`.
  - SH: lanes {`addr[1]`*2, +1}.
  - SW: all lanes.
  - Data is replicated across lanes before masking.
- Legal load `funct3`: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store `funct3`: 000, 001, 010. Any other value is an error.
- Misaligned access is an error: half-word with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Out-of-range access is an error: `addr[31:2]` ≥ `DEPTH_WORDS`.
- On error: no array write, `o_rsp_rdata`=0, `o_rsp_err`=1.
- Load extraction:
  - Byte: lane `addr[1:0]`.
  - Half: lanes selected by `addr[1]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- State transitions:
  - IDLE, accept: LATENCY=1 goes to RESP; otherwise WAIT with counter = LATENCY-2.
  - WAIT: decrement each cycle; go to RESP when the counter is 0.
  - RESP: assert response. A new accept in the same cycle follows the IDLE rules; otherwise go to IDLE.
- Outputs `o_rsp_*` are registered. `o_rsp_rdata` and `o_rsp_err` hold their last value when `o_rsp_valid`=0 (clear to 0 only on reset).

## Timing
- Request accepted at edge E. `o_rsp_valid` is high for exactly the one cycle following edge E+LATENCY-1.
- LATENCY=1: back-to-back accepts give one response per cycle (full throughput).
- A store's write is visible to a load accepted at any later edge, including the very next edge.
- `i_rst_n` low at any time, including mid-WAIT or mid-CLEAR:
  - Immediately forces `o_rsp_valid`=0, `o_rsp_err`=0, `o_rsp_rdata`=0, and counters to 0.
  - Any in-flight response is dropped.
  - Array contents are not touched by reset itself.
- Reset state:
  - With the clear feature enabled: CLEAR, with `o_req_ready`=0 and `o_busy`=1.
  - Without it: IDLE, with `o_req_ready`=1 and `o_busy`=0.

## Configuration
- Macro: `DMEM_CLEAR_ON_RESET_EN`.
- Defined:
  - After `i_rst_n` rises, CLEAR writes 0 to word index 0..DEPTH_WORDS-1, one word per cycle.
  - `o_busy`=1 and `o_req_ready`=0 for exactly DEPTH_WORDS cycles, then IDLE.
  - Reset during the sweep restarts it from index 0.
- Undefined: no CLEAR state. Contents persist across reset, and are uninitialised until written.

## Test plan
- Clear sweep (macro defined, DEPTH_WORDS=16): release reset → `o_busy` high for exactly 16 cycles, then `o_req_ready`=1. LW from 0x3C → 0x00000000, `err`=0.
- Store/load lanes: SW 0x10 = 0x8899AABB, then SB 0x11 with wdata 0x7F.
  - LW 0x10 → 0x88997FBB.
  - LB 0x13 → 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH 0x12 → 0xFFFF8899.
  - LHU 0x10 → 0x00007FBB.
- Faults:
  - LW 0x02 → `err`=1, `rdata`=0.
  - SH 0x05 → `err`=1, and the word at 0x04 is unchanged.
  - `funct3`=011 → `err`=1.
  - Address 4*DEPTH_WORDS → `err`=1.
- Latency (LATENCY=3): accept at edge 10 → `o_rsp_valid` high only in the cycle after edge 12. `o_req_ready`=0 in the cycles after edges 10 and 11.
- Throughput (LATENCY=1): 8 consecutive accepted loads → 8 consecutive response pulses. A SW then an LW to the same address on adjacent edges → the LW returns the new data.
- Reset mid-WAIT (LATENCY=4): assert `i_rst_n`=0 two cycles after accept → no response ever appears, and all outputs are 0 immediately.
